// File: rtl/kpyd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kpyd_pkg
// Description : Shared types and constants for the 4x4 Pmod keypad scanner.
//               Holds the scan FSM state encoding, the scan classification
//               type, the row/column counts and the key-code table.
// Revision    : 1.0 - initial release
// ============================================================================
package kpyd_pkg;

    localparam int c_num_rows = 4;
    localparam int c_num_cols = 4;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_EVAL   = 2'd2
    } scan_state_t;

    typedef enum logic [1:0] {
        CLS_NONE  = 2'd0,
        CLS_ONE   = 2'd1,
        CLS_MULTI = 2'd2
    } scan_class_t;

    // Key codes indexed [row][col]; ascending ranges keep the literal in
    // reading order (row 0 first, column 0 first within a row).
    localparam logic [0:3][0:3][3:0] c_key_map = {
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        return c_key_map[row][col];
    endfunction

endpackage
`default_nettype wire

// File: rtl/kpyd_debounce.sv
`default_nettype none
// ============================================================================
// Module      : kpyd_debounce
// Description : Whole-scan debouncer. Counts consecutive identical scan
//               classes and moves the stable state between idle and held(k)
//               once the count reaches debounce_scans_p. Emits a one-cycle
//               press event (combinational, during the eval strobe) whenever
//               the stable state becomes held(k) with a new key k.
// Ports       : clk_i, reset_n_i    - clock, async active-low reset
//               eval_i              - one-cycle strobe, scan result valid
//               class_i, code_i     - scan class and key code of the scan
//               event_o, event_key_o- press event and its key
//               pressed_o           - stable state is held(k)
// Revision    : 1.0 - initial release
// ============================================================================
module kpyd_debounce
    import kpyd_pkg::*;
#(
    parameter int debounce_scans_p = 4
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        eval_i,
    input  scan_class_t class_i,
    input  logic [3:0]  code_i,
    output logic        event_o,
    output logic [3:0]  event_key_o,
    output logic        pressed_o
);

    localparam int                 c_cnt_w   = $clog2(debounce_scans_p + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(debounce_scans_p);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;
    scan_class_t        r_prev_class;
    logic [3:0]         r_prev_code;
    logic               r_held;
    logic [3:0]         r_held_key;

    logic               w_same;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic               w_reached;

    always_comb begin
        // ONE(j) and ONE(k) with j != k are different classes.
        w_same = (class_i == r_prev_class) &&
                 ((class_i != CLS_ONE) || (code_i == r_prev_code));

        w_cnt_next = r_cnt;
        if (class_i == CLS_MULTI) begin
            w_cnt_next = '0;
        end else if (w_same) begin
            w_cnt_next = (r_cnt == c_cnt_max) ? c_cnt_max : r_cnt + 1'b1;
        end else begin
            w_cnt_next = c_cnt_one;
        end

        w_reached = eval_i && (class_i != CLS_MULTI) && (w_cnt_next == c_cnt_max);
        event_o   = w_reached && (class_i == CLS_ONE) &&
                    !(r_held && (r_held_key == code_i));
    end

    assign event_key_o = code_i;
    assign pressed_o   = r_held;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cnt        <= '0;
            r_prev_class <= CLS_NONE;
            r_prev_code  <= 4'h0;
            r_held       <= 1'b0;
            r_held_key   <= 4'h0;
        end else if (eval_i) begin
            r_cnt        <= w_cnt_next;
            r_prev_class <= class_i;
            r_prev_code  <= code_i;
            if (w_reached) begin
                if (class_i == CLS_ONE) begin
                    r_held     <= 1'b1;
                    r_held_key <= code_i;
                end else begin
                    r_held     <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/kpyd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : kpyd_scan_ctrl
// Description : Scan controller for the 4x4 Pmod keypad. Drives one column
//               low at a time, samples the active-low rows after a settle
//               delay, classifies each full scan, debounces it and delivers
//               one key code per debounced press over valid/ready with a
//               single-entry event buffer.
// Ports       : clk_i, reset_n_i - clock, async active-low reset
//               kpyd_row_i       - row sense, active-low
//               kpyd_col_o       - column drive, one-cold
//               key_o, valid_o   - event key and event-available flag
//               ready_i          - consumer accepts the event
//               pressed_o        - debounced single-key-held level
//               overrun_o        - one-cycle pulse when an event is dropped
// Revision    : 1.0 - initial release
// ============================================================================
module kpyd_scan_ctrl
    import kpyd_pkg::*;
#(
    parameter int settle_cycles_p  = 1200,
    parameter int debounce_scans_p = 4
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic [3:0] kpyd_row_i,
    output logic [3:0] kpyd_col_o,
    output logic [3:0] key_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       pressed_o,
    output logic       overrun_o
);

    localparam int                    c_settle_w    = $clog2(settle_cycles_p + 1);
    localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(settle_cycles_p - 1);

    scan_state_t            r_state;
    scan_state_t            w_state_next;
    logic [1:0]             r_col;
    logic [c_settle_w-1:0]  r_settle_cnt;
    logic [3:0][3:0]        r_image;        // [col][row], 1 = key pressed
    logic [3:0]             r_key;
    logic                   r_valid;
    logic                   r_overrun;

    logic                   w_settle_done;
    logic                   w_eval;
    logic [4:0]             w_ones;
    logic [1:0]             w_hit_row;
    logic [1:0]             w_hit_col;
    scan_class_t            w_class;
    logic [3:0]             w_code;
    logic                   w_event;
    logic [3:0]             w_event_key;

    assign w_settle_done = (r_settle_cnt == c_settle_last);
    assign w_eval        = (r_state == ST_EVAL);

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= ST_SETTLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_SETTLE: if (w_settle_done) w_state_next = ST_SAMPLE;
            ST_SAMPLE: w_state_next = (r_col == 2'd3) ? ST_EVAL : ST_SETTLE;
            ST_EVAL:   w_state_next = ST_SETTLE;
            default:   w_state_next = ST_SETTLE;
        endcase
    end

    // Column pointer, settle counter and scan image. The column pointer is
    // not advanced out of column 3 until EVAL, so column 3 stays driven
    // through the evaluation cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_settle_cnt <= '0;
            r_col        <= 2'd0;
            r_image      <= '0;
        end else begin
            case (r_state)
                ST_SETTLE: r_settle_cnt <= w_settle_done ? '0 : r_settle_cnt + 1'b1;
                ST_SAMPLE: begin
                    r_image[r_col] <= ~kpyd_row_i;
                    if (r_col != 2'd3) r_col <= r_col + 2'd1;
                end
                ST_EVAL:   r_col <= 2'd0;
                default:   r_col <= 2'd0;
            endcase
        end
    end

    assign kpyd_col_o = ~(4'b0001 << r_col);

    // ------------------------------------------------------------------
    // Scan classification: NONE / ONE(k) / MULTI
    // ------------------------------------------------------------------
    always_comb begin
        w_ones    = 5'd0;
        w_hit_row = 2'd0;
        w_hit_col = 2'd0;
        for (int c = 0; c < c_num_cols; c++) begin
            for (int r = 0; r < c_num_rows; r++) begin
                if (r_image[c][r]) begin
                    w_ones    = w_ones + 5'd1;
                    w_hit_row = 2'(r);
                    w_hit_col = 2'(c);
                end
            end
        end
        if (w_ones == 5'd0) begin
            w_class = CLS_NONE;
        end else if (w_ones == 5'd1) begin
            w_class = CLS_ONE;
        end else begin
            w_class = CLS_MULTI;
        end
        w_code = key_code(w_hit_row, w_hit_col);
    end

    kpyd_debounce #(
        .debounce_scans_p (debounce_scans_p)
    ) u_debounce (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .eval_i      (w_eval),
        .class_i     (w_class),
        .code_i      (w_code),
        .event_o     (w_event),
        .event_key_o (w_event_key),
        .pressed_o   (pressed_o)
    );

    // ------------------------------------------------------------------
    // Single-entry event buffer. A new event may replace the held one only
    // when the held one is being consumed in the same cycle; otherwise the
    // new event is dropped and flagged.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_key     <= 4'h0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_event) begin
                if (!r_valid || ready_i) begin
                    r_key   <= w_event_key;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign key_o     = r_key;
    assign valid_o   = r_valid;
    assign overrun_o = r_overrun;

endmodule
`default_nettype wire

// File: doc/kpyd_scan_ctrl.md
# kpyd_scan_ctrl

Scan controller for the 4x4 Pmod keypad on the icebreaker board. It drives the keypad columns one at a time and samples the rows after a settle delay. It debounces whole-keypad scans and emits one hex key code per debounced press over a valid/ready interface. It sits between the `kpyd_col_o`/`kpyd_row_i` pins and the downstream consumer, for example the seven-segment display logic.

## Interface
- `settle_cycles_p`, 1200: cycles a column is driven before its rows are sampled (100 us at 12 MHz); must be ≥1.
- `debounce_scans_p`, 4: consecutive identical full scans required to change the debounced state; must be ≥1.
- `clk_i` input 1: the single clock.
- `reset_n_i` input 1: asynchronous, active-low reset.
- `kpyd_row_i` input 4: row sense, active-low (0 = key in the driven column pressed). Already synchronized externally.
- `kpyd_col_o` output 4: column drive, one-cold (exactly one bit 0).
- `key_o` output 4: hex code of the latest event; held stable while `valid_o` = 1.
- `valid_o` output 1: event available.
- `ready_i` input 1: consumer accepts; transfer occurs when `valid_o` & `ready_i`.
- `pressed_o` output 1: level, debounced "a single key is held".
- `overrun_o` output 1: one-cycle pulse when an event is dropped.

## Operation
- Key map, indexed [row][col]:
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: 0 F E D
- FSM states:
  - SETTLE: drive column c, count settle_cycles_p cycles, then go to SAMPLE.
  - SAMPLE: one cycle. Latch ~kpyd_row_i into the scan image for column c. If c<3, set c←c+1 and go to SETTLE. If c=3, go to EVAL.
  - EVAL: one cycle. Classify the 16-bit image as NONE (0 bits), ONE(k) (exactly 1 bit), or MULTI (≥2 bits). Set c←0 and go to SETTLE.
- The column counter wraps 3→0.
- During EVAL, `kpyd_col_o` keeps driving column 3.
- Debounce state:
  - Stable state is {idle, held(k)}.
  - The candidate count increments when the scan class equals the previous scan class. It resets to 1 on a class change.
  - MULTI scans reset the count to 0 and never change the stable state.
- Transitions:
  - When the count reaches `debounce_scans_p` with ONE(k), and the stable state is not held(k): stable←held(k), `pressed_o`←1, emit event k.
  - When the count reaches `debounce_scans_p` with NONE: stable←idle, `pressed_o`←0, no event.
  - held(j)→held(k) with j≠k emits event k.
- Event buffer (one entry):
  - Empty: load key_o←k and set valid_o←1.
  - Full with ready_i=1 in the same cycle: load the new event; valid_o stays 1; no overrun.
  - Full with ready_i=0: drop the new event, pulse overrun_o, leave key_o unchanged.
  - Transfer with no new event: valid_o←0 next cycle.

## Timing
- Reset values: state SETTLE, c=0, `kpyd_col_o`=4'b1110, `key_o`=0, `valid_o`=0, `pressed_o`=0, `overrun_o`=0, all counters 0, stable=idle.
- Reset mid-scan clears everything immediately, without waiting for a clock edge.
- Column period: settle_cycles_p+1 cycles. Scan period T = 4·(settle_cycles_p+1)+1 cycles.
- Event latency: `valid_o` and `pressed_o` rise on the cycle after the EVAL of the debounce_scans_p-th consecutive matching scan.
- Release latency: `pressed_o` falls on the cycle after the EVAL of the debounce_scans_p-th consecutive NONE scan.
- Settle counter width: $clog2(settle_cycles_p+1).
- Debounce counter width: $clog2(debounce_scans_p+1). It saturates at debounce_scans_p.
- `ready_i` is a don't-care while `valid_o`=0.

## Structure
- Package `kpyd_pkg`:
  - FSM state enum (SETTLE, SAMPLE, EVAL).
  - Scan class enum (NONE, ONE, MULTI).
  - 4x4 key-code table constant.
  - Row and column count constants.
- Sub-module `kpyd_debounce`: takes {class, code, eval strobe}; outputs stable state, press event, and `pressed_o`.
- The scan FSM, image register and event buffer live in `kpyd_scan_ctrl`.

## Test plan
All scenarios use settle_cycles_p=3 and debounce_scans_p=2 (T=17).
- Reset: hold `reset_n_i`=0 → `kpyd_col_o`=1110, `valid_o`=0. Release → column sequence 1110, 1101, 1011, 0111, 1110 at 4-cycle spacing.
- Press row 1 / col 2 (row bit low only while column 2 is driven) for 3 scans, `ready_i`=1 → single transfer with `key_o`=6, `pressed_o`=1. After release for 2 scans → `pressed_o`=0, no further event.
- Press row 3 / col 0 and row 0 / col 3 simultaneously → MULTI, no event, `pressed_o` unchanged.
- Bounce: alternate 5 / none on every scan → no event ever.
- `ready_i`=0 while pressing 1, releasing, then pressing 2 → `key_o`=1 held, `overrun_o` pulses once. Then `ready_i`=1 → one transfer of 1.
- Assert `reset_n_i` low mid-SETTLE of column 2 with `valid_o`=1 → all outputs return to reset values immediately.
